// File: rtl/param_sram.sv
// param_sram: byte-masked single-write, multi-read-port SRAM with a configurable
// read latency and same-address collision policy; array contents survive reset.
module param_sram #(
  parameter int DATA_W       = 256,
  parameter int DEPTH        = 1800,
  parameter int ADDR_W       = 11,
  parameter int N_RD         = 2,
  parameter int RD_LAT       = 1,
  parameter int COLLIDE_MODE = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     WE,
  input  logic [ADDR_W-1:0]        WriteAddress,
  input  logic [DATA_W/8-1:0]      WriteMask,
  input  logic [DATA_W-1:0]        WriteBus,
  input  logic [N_RD-1:0]          RE,
  input  logic [N_RD*ADDR_W-1:0]   ReadAddress,
  output logic [N_RD*DATA_W-1:0]   ReadBus,
  output logic [N_RD-1:0]          ReadValid,
  output logic                     AddrErr,
  output logic [31:0]              WriteCount
);
  localparam int          N_BYTES       = DATA_W / 8;
  localparam logic [31:0] DEPTH_U       = 32'(DEPTH);
  localparam bit          WRITE_THROUGH = (COLLIDE_MODE != 32'sd0);

  function automatic logic inRange(input logic [ADDR_W-1:0] addr);
    return 64'(addr) < 64'(DEPTH_U);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic                writeOk;
  logic [N_RD-1:0]     readInRange;
  logic [ADDR_W-1:0]   readAddr [N_RD];
  logic [DATA_W-1:0]   readWord [N_RD];
  logic [N_RD-1:0]     pipeValid [RD_LAT];
  logic [DATA_W-1:0]   pipeData [RD_LAT][N_RD];

  // Per-port word captured at this edge; write-through merges the in-flight write bytes.
  always_comb begin
    logic [DATA_W-1:0] word;
    writeOk = WE & inRange(WriteAddress);
    for (int p = 0; p < N_RD; p++) begin
      readAddr[p]    = ReadAddress[p*ADDR_W +: ADDR_W];
      readInRange[p] = inRange(readAddr[p]);
      word           = '0;
      if (readInRange[p]) begin
        word = mem[readAddr[p]];
        if (WRITE_THROUGH && writeOk && (WriteAddress == readAddr[p])) begin
          for (int b = 0; b < N_BYTES; b++) begin
            word[b*8 +: 8] = WriteMask[b] ? WriteBus[b*8 +: 8] : word[b*8 +: 8];
          end
        end else begin
          word = mem[readAddr[p]];
        end
      end else begin
        word = '0;
      end
      readWord[p] = word;
    end
  end

  // Byte-masked array write; contents deliberately keep their value through reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (reset_n) begin
      if (writeOk) begin
        for (int b = 0; b < N_BYTES; b++) begin
          if (WriteMask[b]) begin
            mem[WriteAddress][b*8 +: 8] <= WriteBus[b*8 +: 8];
          end
        end
      end
    end
  end

  // Read pipeline; data stages only load on valid so the last stage holds between reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < RD_LAT; s++) begin
        pipeValid[s] <= '0;
        for (int p = 0; p < N_RD; p++) begin
          pipeData[s][p] <= '0;
        end
      end
    end else begin
      pipeValid[0] <= RE;
      for (int p = 0; p < N_RD; p++) begin
        if (RE[p]) begin
          pipeData[0][p] <= readWord[p];
        end
      end
      for (int s = 1; s < RD_LAT; s++) begin
        pipeValid[s] <= pipeValid[s-1];
        for (int p = 0; p < N_RD; p++) begin
          if (pipeValid[s-1][p]) begin
            pipeData[s][p] <= pipeData[s-1][p];
          end
        end
      end
    end
  end

  // Sticky out-of-range flag and committed-write counter (wraps naturally at 32 bits).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      AddrErr    <= 1'b0;
      WriteCount <= 32'd0;
    end else begin
      if ((WE && !inRange(WriteAddress)) || (|(RE & ~readInRange))) begin
        AddrErr <= 1'b1;
      end
      if (writeOk) begin
        WriteCount <= WriteCount + 32'd1;
      end
    end
  end

  // Output taps come straight from the last pipeline stage.
  always_comb begin
    ReadBus   = '0;
    ReadValid = pipeValid[RD_LAT-1];
    for (int p = 0; p < N_RD; p++) begin
      ReadBus[p*DATA_W +: DATA_W] = pipeData[RD_LAT-1][p];
    end
  end

endmodule

// File: tb/tb_param_sram.sv
// Self-checking bench for param_sram: a default instance (latency 1, read-old) and a
// latency-3 write-through instance share randomized stimulus against a word-level model.
module tb_param_sram;
  localparam int DW = 256, DEPTH = 1800, AW = 11, NR = 2, NB = DW / 8, HIST = 8192;

  logic clock = 1'b0;
  logic reset_n;
  logic WE;
  logic [AW-1:0] WriteAddress;
  logic [NB-1:0] WriteMask;
  logic [DW-1:0] WriteBus;
  logic [NR-1:0] RE;
  logic [NR*AW-1:0] ReadAddress;
  logic [NR*DW-1:0] busA, busB;
  logic [NR-1:0] vldA, vldB;
  logic errA, errB;
  logic [31:0] cntA, cntB;

  int nChecks = 0;
  int nFail = 0;

  logic [DW-1:0] mdl [DEPTH];
  bit            hv [HIST][NR];
  logic [DW-1:0] hdOld [HIST][NR];
  logic [DW-1:0] hdNew [HIST][NR];
  logic [DW-1:0] lastA [NR];
  logic [DW-1:0] lastB [NR];
  int cyc = 0;
  int firstEdge = 1;
  logic errM = 1'b0;
  logic [31:0] cntM = 32'd0;
  logic [DW-1:0] saved;

  param_sram dutA (
    .clock(clock), .reset_n(reset_n), .WE(WE), .WriteAddress(WriteAddress),
    .WriteMask(WriteMask), .WriteBus(WriteBus), .RE(RE), .ReadAddress(ReadAddress),
    .ReadBus(busA), .ReadValid(vldA), .AddrErr(errA), .WriteCount(cntA)
  );

  param_sram #(.RD_LAT(3), .COLLIDE_MODE(1)) dutB (
    .clock(clock), .reset_n(reset_n), .WE(WE), .WriteAddress(WriteAddress),
    .WriteMask(WriteMask), .WriteBus(WriteBus), .RE(RE), .ReadAddress(ReadAddress),
    .ReadBus(busB), .ReadValid(vldB), .AddrErr(errB), .WriteCount(cntB)
  );

  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit inRng(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic [AW-1:0] pickAddr();
    int r;
    r = $urandom_range(0, 19);
    if (r < 12) return AW'($urandom_range(0, 7));
    else if (r < 18) return AW'($urandom_range(0, DEPTH - 1));
    else return AW'($urandom_range(DEPTH, 2047));
  endfunction

  task automatic idle();
    WE = 1'b0; WriteAddress = '0; WriteMask = '0; WriteBus = '0;
    RE = '0; ReadAddress = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [DW-1:0] d);
    WE = 1'b1; WriteAddress = a; WriteMask = m; WriteBus = d;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    RE[p] = 1'b1;
    ReadAddress[p*AW +: AW] = a;
  endtask

  // One clock edge: log what the model says each read returns, apply the write, check outputs.
  task automatic tick();
    logic [AW-1:0] ra;
    logic [DW-1:0] oldW, newW;
    logic expV;
    @(posedge clock);
    cyc++;
    for (int p = 0; p < NR; p++) begin
      ra   = ReadAddress[p*AW +: AW];
      oldW = inRng(ra) ? mdl[ra] : '0;
      newW = oldW;
      if (WE && inRng(ra) && (WriteAddress == ra)) begin
        for (int b = 0; b < NB; b++) if (WriteMask[b]) newW[b*8 +: 8] = WriteBus[b*8 +: 8];
      end
      hv[cyc][p]    = RE[p];
      hdOld[cyc][p] = oldW;
      hdNew[cyc][p] = newW;
      if (RE[p] && !inRng(ra)) errM = 1'b1;
    end
    if (WE) begin
      if (inRng(WriteAddress)) begin
        cntM = cntM + 32'd1;
        for (int b = 0; b < NB; b++)
          if (WriteMask[b]) mdl[WriteAddress][b*8 +: 8] = WriteBus[b*8 +: 8];
      end else begin
        errM = 1'b1;
      end
    end
    #1;
    for (int p = 0; p < NR; p++) begin
      if (hv[cyc][p]) lastA[p] = hdOld[cyc][p];
      checkVal($sformatf("A.valid%0d", p), DW'(vldA[p]), DW'(hv[cyc][p]));
      checkVal($sformatf("A.bus%0d", p), busA[p*DW +: DW], lastA[p]);
      expV = (cyc >= firstEdge + 2) ? hv[cyc-2][p] : 1'b0;
      if (expV) lastB[p] = hdNew[cyc-2][p];
      checkVal($sformatf("B.valid%0d", p), DW'(vldB[p]), DW'(expV));
      checkVal($sformatf("B.bus%0d", p), busB[p*DW +: DW], lastB[p]);
    end
    checkVal("A.addrErr", DW'(errA), DW'(errM));
    checkVal("B.addrErr", DW'(errB), DW'(errM));
    checkVal("A.writeCount", DW'(cntA), DW'(cntM));
    checkVal("B.writeCount", DW'(cntB), DW'(cntM));
  endtask

  task automatic checkZero(input string tag);
    checkVal({tag, ".A.valid"}, DW'(vldA), '0);
    checkVal({tag, ".B.valid"}, DW'(vldB), '0);
    for (int p = 0; p < NR; p++) begin
      checkVal($sformatf("%s.A.bus%0d", tag, p), busA[p*DW +: DW], '0);
      checkVal($sformatf("%s.B.bus%0d", tag, p), busB[p*DW +: DW], '0);
    end
    checkVal({tag, ".A.err"}, DW'(errA), '0);
    checkVal({tag, ".B.err"}, DW'(errB), '0);
    checkVal({tag, ".A.cnt"}, DW'(cntA), '0);
    checkVal({tag, ".B.cnt"}, DW'(cntB), '0);
  endtask

  // Called #1 after an edge with whatever requests are pending; they must be dropped.
  task automatic applyReset();
    #2 reset_n = 1'b0;
    #1 checkZero("reset");
    repeat (2) @(posedge clock);
    #1 checkZero("inReset");
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    firstEdge = cyc + 1;
    errM = 1'b0;
    cntM = 32'd0;
    for (int p = 0; p < NR; p++) begin
      lastA[p] = '0;
      lastB[p] = '0;
    end
  endtask

  initial begin
    idle();
    for (int p = 0; p < NR; p++) begin
      lastA[p] = '0;
      lastB[p] = '0;
    end
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    #1 checkZero("por");
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    firstEdge = cyc + 1;

    // Fill every word so later reads have a defined model value.
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      for (int i = 0; i < DW / 32; i++) WriteBus[i*32 +: 32] = $urandom();
      WE = 1'b1; WriteAddress = AW'(a); WriteMask = '1;
      tick();
    end

    // Basic write then read on port 0.
    idle(); wr(AW'(5), '1, {NB{8'hA5}}); tick();
    idle(); rd(0, AW'(5)); tick();
    checkVal("basic.valid", DW'(vldA[0]), DW'(1'b1));
    checkVal("basic.bus", busA[0 +: DW], {NB{8'hA5}});
    checkVal("basic.count", DW'(cntA), DW'(32'd1801));

    // Single-byte mask over word 0.
    saved = mdl[0];
    idle(); wr(AW'(0), NB'(1), '1); tick();
    idle(); rd(0, AW'(0)); tick();
    checkVal("mask.byte0", DW'(busA[7:0]), DW'(8'hFF));
    checkVal("mask.upper", DW'(busA[DW-1:8]), DW'(saved[DW-1:8]));

    // All-zero mask counts but changes nothing.
    idle(); wr(AW'(3), '0, '1); tick();
    idle(); rd(1, AW'(3)); tick();

    // Same-edge write and read of address 7.
    idle(); wr(AW'(7), '1, DW'(2)); tick();
    idle(); wr(AW'(7), '1, DW'(1)); rd(1, AW'(7)); tick();
    checkVal("collide.old", busA[DW +: DW], DW'(2));
    idle(); tick(); tick();
    checkVal("collide.new", busB[DW +: DW], DW'(1));

    // Back-to-back reads on port 0 through the latency-3 instance.
    for (int a = 0; a < 3; a++) begin
      idle(); rd(0, AW'(a)); tick();
    end
    idle(); repeat (4) tick();

    // Out-of-range write and read.
    saved = mdl[DEPTH-1];
    idle(); wr(AW'(1800), '1, '1); rd(0, AW'(2047)); tick();
    checkVal("oor.err", DW'(errA), DW'(1'b1));
    checkVal("oor.bus", busA[0 +: DW], '0);
    idle(); repeat (3) tick();
    rd(0, AW'(DEPTH - 1)); tick();
    idle(); repeat (3) tick();
    checkVal("oor.noWrite", busB[0 +: DW], saved);

    // Reset with reads in flight and a write pending; both must be dropped.
    idle(); rd(0, AW'(10)); rd(1, AW'(11)); tick();
    rd(0, AW'(12)); rd(1, AW'(13)); wr(AW'(10), '1, '0);
    applyReset();
    repeat (4) tick();
    rd(0, AW'(10)); rd(1, AW'(5)); tick();
    idle(); repeat (3) tick();
    checkVal("retain.bus1", busB[DW +: DW], {NB{8'hA5}});

    // Randomized traffic concentrated on a few addresses to force collisions.
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) begin
        WE = 1'b1;
        WriteAddress = pickAddr();
        case ($urandom_range(0, 5))
          0: WriteMask = '0;
          1: WriteMask = '1;
          default: WriteMask = NB'($urandom());
        endcase
        for (int i = 0; i < DW / 32; i++) WriteBus[i*32 +: 32] = $urandom();
      end
      for (int p = 0; p < NR; p++) begin
        if ($urandom_range(0, 2) != 0) rd(p, pickAddr());
      end
      tick();
    end
    idle(); repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
